// File: rtl/rf_pkg.sv
// Shared types and helpers for the multiport register file.
// Optional difftest trace outputs are enabled with RF_TRACE_EN.
package rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int CNT_W_DEF = 2;
    localparam int CNT_MAX   = (1 << CNT_W_DEF) - 1;
    localparam int MERGE_W   = 256;

    // Widest supported lane merge; callers cast to their own DATA_W.
    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0]   old_v,
        input logic [MERGE_W-1:0]   new_v,
        input logic [MERGE_W/8-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_v;
        for (int i = 0; i < MERGE_W / 8; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_v[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters driving read-busy and issue stall.
// Register 0 never holds a pending writer.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     rf_clk,
    input  logic                     rf_rst_n,
    input  logic                     sb_ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     sb_flush,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     iss_full
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] SAT = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [DEPTH];

    always_ff @(posedge rf_clk or negedge rf_rst_n) begin
        if (!rf_rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                cnt_q[r] <= '0;
            end
        end else if (sb_ready) begin
            for (int r = 1; r < DEPTH; r++) begin
                if (sb_flush) begin
                    cnt_q[r] <= '0;
                end else if (iss_en && iss_addr == ADDR_W'(r)
                             && !(wr_en && wr_addr == ADDR_W'(r))
                             && cnt_q[r] != SAT) begin
                    cnt_q[r] <= cnt_q[r] + ONE;
                end else if (wr_en && wr_addr == ADDR_W'(r)
                             && !(iss_en && iss_addr == ADDR_W'(r))
                             && cnt_q[r] != '0) begin
                    cnt_q[r] <= cnt_q[r] - ONE;
                end
            end
        end
    end

    // A writer retiring this cycle releases the last pending count early.
    always_comb begin
        rd_busy = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_busy[p] = sb_ready
                && rd_addr[p*ADDR_W +: ADDR_W] != '0
                && cnt_q[rd_addr[p*ADDR_W +: ADDR_W]] != '0
                && !(wr_en
                     && wr_addr == rd_addr[p*ADDR_W +: ADDR_W]
                     && cnt_q[rd_addr[p*ADDR_W +: ADDR_W]] == ONE);
        end
    end

    always_comb begin
        iss_full = !sb_ready
            || (iss_addr != '0
                && cnt_q[iss_addr] == SAT
                && !(wr_en && wr_addr == iss_addr));
    end

endmodule

// File: rtl/rf_sb_multiport.sv
// Multiport register file with bypass, scoreboard and post-reset clear.
// Define RF_TRACE_EN to expose the debug_wb_* difftest trace outputs.
module rf_sb_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     rf_clk,
    input  logic                     rf_rst_n,
    output logic                     rf_ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_full,
    input  logic                     sb_flush
`ifdef RF_TRACE_EN
    ,
    output logic                     debug_wb_en,
    output logic [ADDR_W-1:0]        debug_wb_reg,
    output logic [DATA_W-1:0]        debug_wb_value
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    rf_state_e         state_q;
    rf_state_e         state_d;
    logic [ADDR_W-1:0] clr_idx_q;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] wb_value;
    logic              wb_live;

    always_ff @(posedge rf_clk or negedge rf_rst_n) begin
        if (!rf_rst_n) begin
            state_q   <= CLEAR;
            clr_idx_q <= ADDR_W'(1);
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) begin
                clr_idx_q <= clr_idx_q + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR: if (clr_idx_q == ADDR_W'(DEPTH - 1)) state_d = READY;
            READY: state_d = READY;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        rf_ready = (state_q == READY);
    end

    always_comb begin
        wb_value = DATA_W'(byte_merge(
            MERGE_W'(regs_q[wr_addr]),
            MERGE_W'(wr_data),
            (MERGE_W/8)'(wr_be)));
        wb_live  = rf_ready && wr_en && wr_addr != '0;
    end

    // Storage has no reset; the clear sequencer zeroes it instead.
    always_ff @(posedge rf_clk) begin
        if (!rf_ready) begin
            regs_q[clr_idx_q] <= '0;
        end else if (wb_live) begin
            regs_q[wr_addr] <= wb_value;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rf_ready && rd_addr[p*ADDR_W +: ADDR_W] != '0) begin
                if (wr_en && wr_addr == rd_addr[p*ADDR_W +: ADDR_W]) begin
                    rd_data[p*DATA_W +: DATA_W] = wb_value;
                end else begin
                    rd_data[p*DATA_W +: DATA_W] =
                        regs_q[rd_addr[p*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .CNT_W  (CNT_W)
    ) u_sb (
        .rf_clk   (rf_clk),
        .rf_rst_n (rf_rst_n),
        .sb_ready (rf_ready),
        .rd_addr  (rd_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .sb_flush (sb_flush),
        .rd_busy  (rd_busy),
        .iss_full (iss_full)
    );

`ifdef RF_TRACE_EN
    assign debug_wb_en    = wb_live;
    assign debug_wb_reg   = wr_addr;
    assign debug_wb_value = wb_value;
`endif

endmodule

// File: tb/tb_rf_sb_multiport.sv
// Randomised and directed bench for rf_sb_multiport against a behavioural model.
// Default configuration: DATA_W=32, ADDR_W=5, NUM_RD=2, CNT_W=2.
module tb_rf_sb_multiport;
    import rf_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic           rf_clk = 1'b0;
    logic           rf_rst_n = 1'b0;
    logic           rf_ready;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]  rd_busy;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW/8-1:0] wr_be = '0;
    logic [DW-1:0]  wr_data = '0;
    logic           iss_en = 1'b0;
    logic [AW-1:0]  iss_addr = '0;
    logic           iss_full;
    logic           sb_flush = 1'b0;
`ifdef RF_TRACE_EN
    logic           debug_wb_en;
    logic [AW-1:0]  debug_wb_reg;
    logic [DW-1:0]  debug_wb_value;
`endif

    always #5 rf_clk = ~rf_clk;

    rf_sb_multiport #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR),
        .CNT_W  (CNT_W_DEF)
    ) dut (
        .rf_clk   (rf_clk),
        .rf_rst_n (rf_rst_n),
        .rf_ready (rf_ready),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .iss_full (iss_full),
        .sb_flush (sb_flush)
`ifdef RF_TRACE_EN
        ,
        .debug_wb_en    (debug_wb_en),
        .debug_wb_reg   (debug_wb_reg),
        .debug_wb_value (debug_wb_value)
`endif
    );

    logic [DW-1:0] m_reg [DEPTH];
    int            m_cnt [DEPTH];
    bit            m_ready;
    int            m_clr;
    int            n_checks = 0;
    int            n_fail = 0;

    function automatic logic [DW-1:0] merge_m(input logic [DW-1:0] o,
                                              input logic [DW-1:0] n,
                                              input logic [DW/8-1:0] be);
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 8; i++) begin
            r[i*8 +: 8] = be[i] ? n[i*8 +: 8] : o[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (!m_ready || a == 0) return '0;
        if (wr_en && wr_addr == a) return merge_m(m_reg[a], wr_data, wr_be);
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (!m_ready || a == 0) return 1'b0;
        return m_cnt[a] != 0 && !(wr_en && wr_addr == a && m_cnt[a] == 1);
    endfunction

    function automatic logic exp_full();
        if (!m_ready) return 1'b1;
        if (iss_addr == 0) return 1'b0;
        return m_cnt[iss_addr] == CNT_MAX && !(wr_en && wr_addr == iss_addr);
    endfunction

    task automatic model_reset();
        m_ready = 1'b0;
        m_clr = 0;
        for (int r = 0; r < DEPTH; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
        end
    endtask

    // Advance one clock, updating the model from the inputs held this cycle.
    task automatic step();
        if (rf_rst_n) begin
            if (!m_ready) begin
                m_clr++;
                if (m_clr == DEPTH - 1) m_ready = 1'b1;
            end else begin
                if (wr_en && wr_addr != 0)
                    m_reg[wr_addr] = merge_m(m_reg[wr_addr], wr_data, wr_be);
                for (int r = 1; r < DEPTH; r++) begin
                    bit inc, dec;
                    inc = iss_en && iss_addr == AW'(r);
                    dec = wr_en && wr_addr == AW'(r);
                    if (sb_flush) m_cnt[r] = 0;
                    else if (inc && !dec && m_cnt[r] < CNT_MAX) m_cnt[r]++;
                    else if (dec && !inc && m_cnt[r] > 0) m_cnt[r]--;
                end
            end
        end
        @(posedge rf_clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        iss_en = 1'b0;
        sb_flush = 1'b0;
        wr_be = '0;
    endtask

    task automatic test_reset();
        idle();
        rf_rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge rf_clk);
        #1;
        n_checks++;
        if (rf_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", rf_ready);
        end
        rf_rst_n = 1'b1;
        for (int k = 0; k < DEPTH - 1; k++) begin
            #1;
            n_checks++;
            if (rf_ready !== 1'b0 || iss_full !== 1'b1) begin
                n_fail++;
                $display("FAIL clear_cycle%0d: ready=%b full=%b expected 0/1",
                         k, rf_ready, iss_full);
            end
            step();
        end
        #1;
        n_checks++;
        if (rf_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_clear: got %b expected 1", rf_ready);
        end
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = {AW'(a), AW'(DEPTH - 1 - a)};
            #1;
            n_checks++;
            if (rd_data !== '0) begin
                n_fail++;
                $display("FAIL cleared_reg%0d: got %h expected 0", a, rd_data);
            end
        end
    endtask

    task automatic test_write_merge();
        idle();
        wr_en = 1'b1; wr_addr = 5; wr_be = 4'b1111; wr_data = 32'hDEADBEEF;
        step();
        wr_be = 4'b0001; wr_data = 32'h000000AA;
        step();
        idle();
        rd_addr = {AW'(0), AW'(5)};
        #1;
        n_checks++;
        if (rd_data[DW-1:0] !== 32'hDEADBEAA) begin
            n_fail++;
            $display("FAIL byte_merge: got %h expected deadbeaa", rd_data[DW-1:0]);
        end
    endtask

    task automatic test_bypass();
        idle();
        wr_en = 1'b1; wr_addr = 7; wr_be = 4'b1111; wr_data = 32'h12345678;
        rd_addr = {AW'(7), AW'(7)};
        #1;
        n_checks++;
        if (rd_data !== {32'h12345678, 32'h12345678}) begin
            n_fail++;
            $display("FAIL bypass_full: got %h expected 12345678 x2", rd_data);
        end
        step();
        wr_be = 4'b0010; wr_data = 32'h0000AB00;
        #1;
        n_checks++;
        if (rd_data[DW-1:0] !== 32'h1234AB78) begin
            n_fail++;
            $display("FAIL bypass_merge: got %h expected 1234ab78", rd_data[DW-1:0]);
        end
        step();
        wr_addr = 0; wr_be = 4'b1111; wr_data = 32'h0000FFFF;
        rd_addr = {AW'(7), AW'(0)};
        #1;
        n_checks++;
        if (rd_data[DW-1:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_bypass: got %h expected 0", rd_data[DW-1:0]);
        end
        step();
        idle();
        #1;
        n_checks++;
        if (rd_data !== {32'h1234AB78, 32'h0}) begin
            n_fail++;
            $display("FAIL r0_write: got %h expected 1234ab78_00000000", rd_data);
        end
    endtask

    task automatic test_saturate();
        idle();
        iss_en = 1'b1; iss_addr = 3;
        rd_addr = {AW'(0), AW'(3)};
        repeat (3) step();
        iss_en = 1'b0;
        #1;
        n_checks++;
        if (rd_busy[0] !== 1'b1 || iss_full !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_three: busy=%b full=%b expected 1/1", rd_busy[0], iss_full);
        end
        iss_en = 1'b1;
        step();
        iss_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = 3; wr_be = 4'hF; wr_data = $urandom;
            #1;
            n_checks++;
            if (rd_busy[0] !== (i != 2) || iss_full !== 1'b0) begin
                n_fail++;
                $display("FAIL wb%0d: busy=%b full=%b expected %b/0",
                         i, rd_busy[0], iss_full, i != 2);
            end
            step();
        end
        idle();
        #1;
        n_checks++;
        if (rd_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_drained: busy=%b expected 0", rd_busy[0]);
        end
    endtask

    task automatic test_same_cycle_flush();
        idle();
        iss_en = 1'b1; iss_addr = 4;
        step();
        wr_en = 1'b1; wr_addr = 4; wr_be = 4'hF; wr_data = 32'h11112222;
        step();
        idle();
        iss_en = 1'b1; iss_addr = 9;
        step();
        idle();
        rd_addr = {AW'(9), AW'(4)};
        #1;
        n_checks++;
        if (rd_busy !== 2'b11) begin
            n_fail++;
            $display("FAIL iss_wr_same: busy=%b expected 11", rd_busy);
        end
        sb_flush = 1'b1;
        iss_en = 1'b1; iss_addr = 10;
        wr_en = 1'b1; wr_addr = 4; wr_be = 4'hF; wr_data = 32'hCAFEF00D;
        step();
        idle();
        rd_addr = {AW'(10), AW'(4)};
        #1;
        n_checks++;
        if (rd_busy !== 2'b00 || rd_data[DW-1:0] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL flush: busy=%b data=%h expected 00/cafef00d",
                     rd_busy, rd_data[DW-1:0]);
        end
        rd_addr = {AW'(9), AW'(9)};
        #1;
        n_checks++;
        if (rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_r9: busy=%b expected 00", rd_busy);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rd_addr  = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            wr_en    = ($urandom % 2) == 1;
            wr_addr  = AW'($urandom_range(0, 7));
            wr_be    = 4'($urandom);
            wr_data  = $urandom;
            iss_en   = ($urandom % 3) != 0;
            iss_addr = AW'($urandom_range(0, 7));
            sb_flush = ($urandom % 24) == 0;
            #1;
            for (int p = 0; p < NR; p++) begin
                n_checks++;
                if (rd_data[p*DW +: DW] !== exp_rd(rd_addr[p*AW +: AW])
                    || rd_busy[p] !== exp_busy(rd_addr[p*AW +: AW])) begin
                    n_fail++;
                    $display("FAIL rand_port%0d c%0d: data=%h busy=%b expected %h/%b",
                             p, c, rd_data[p*DW +: DW], rd_busy[p],
                             exp_rd(rd_addr[p*AW +: AW]), exp_busy(rd_addr[p*AW +: AW]));
                end
            end
            n_checks++;
            if (iss_full !== exp_full()) begin
                n_fail++;
                $display("FAIL rand_full c%0d: got %b expected %b", c, iss_full, exp_full());
            end
            step();
        end
        idle();
    endtask

    task automatic test_reset_mid_clear();
        idle();
        rf_rst_n = 1'b0;
        model_reset();
        @(posedge rf_clk);
        #1;
        rf_rst_n = 1'b1;
        repeat (10) step();
        rf_rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (rf_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ready: got %b expected 0", rf_ready);
        end
        @(posedge rf_clk);
        #1;
        rf_rst_n = 1'b1;
        iss_en = 1'b1; iss_addr = 6;
        rd_addr = {AW'(0), AW'(6)};
        for (int k = 0; k < DEPTH - 1; k++) begin
            #1;
            n_checks++;
            if (rf_ready !== 1'b0 || iss_full !== 1'b1 || rd_busy !== 2'b00) begin
                n_fail++;
                $display("FAIL reclear_cycle%0d: ready=%b full=%b busy=%b expected 0/1/00",
                         k, rf_ready, iss_full, rd_busy);
            end
            step();
        end
        iss_en = 1'b0;
        #1;
        n_checks++;
        if (rf_ready !== 1'b1 || rd_busy[0] !== 1'b0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL reclear_done: ready=%b busy=%b data=%h expected 1/0/0",
                     rf_ready, rd_busy[0], rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_write_merge();
        test_bypass();
        test_saturate();
        test_same_cycle_flush();
        test_random();
        test_reset_mid_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
